// File: rtl/register_write_bank_pkg.sv
// -----------------------------------------------------------------------------
// regfile_defs
// Shared register-file definitions, used by both the write bank and the
// read-port multiplexers.
//   REG_COUNT  : number of architectural registers
//   REG_ADDR_W : width of a register index
//   ZERO_REG   : index of the hardwired-zero register
//   COUNT_MAX  : saturation value of the committed-write counter
// -----------------------------------------------------------------------------
package regfile_defs;

   localparam int          REG_COUNT  = 32;
   localparam int          REG_ADDR_W = 5;
   localparam int          ZERO_REG   = 0;
   localparam logic [15:0] COUNT_MAX  = 16'hFFFF;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [REG_COUNT-1:0]  reg_onehot_t;

endpackage : regfile_defs

// File: rtl/register_write_bank_write_decoder.sv
// -----------------------------------------------------------------------------
// write_decoder
// Combinational 5-bit to 32 one-hot write-enable decoder.
//   we_i   : write enable from the control unit
//   addr_i : destination register index
//   en_o   : one-hot enable, bit ZERO_REG always low
// -----------------------------------------------------------------------------
module write_decoder
   import regfile_defs::*;
(
   input  logic        we_i,
   input  reg_addr_t   addr_i,
   output reg_onehot_t en_o
);

   always_comb begin
      // NOTE: every output of a combinational block gets a default before any
      // conditional assignment; otherwise synthesis infers a latch.
      en_o = '0;
      // Each of the 32 indices gets its own compare, so the decode is complete.
      // An unknown address while we_i is low stays out of the compare entirely.
      if (we_i) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            if (addr_i == REG_ADDR_W'(i)) en_o[i] = 1'b1;
         end
      end
      en_o[ZERO_REG] = 1'b0;
   end

endmodule : write_decoder

// File: rtl/register_write_bank.sv
// -----------------------------------------------------------------------------
// register_write_bank
// Write side of the 32-entry register file. Decodes the write address into a
// one-hot enable and stores Write_Data into the selected N-bit register.
// Register 0 is hardwired to zero. No read-during-write bypass.
//   clk            : rising-edge clock
//   reset          : asynchronous active-low reset
//   RegWrite       : write enable
//   Write_Register : destination index 0..31
//   Write_Data     : value to store (stored unmodified)
//   Reg_Q          : all registers, register k at [k*N +: N]
//   Write_Onehot   : registered copy of the enable applied on the last edge
//   Write_Count    : committed writes since reset, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module register_write_bank
   import regfile_defs::*;
#(
   parameter int          N           = 32,
   parameter logic [N-1:0] RESET_VALUE = '0
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 RegWrite,
   input  logic [4:0]           Write_Register,
   input  logic [N-1:0]         Write_Data,
   output logic [REG_COUNT*N-1:0] Reg_Q,
   output logic [31:0]          Write_Onehot,
   output logic [15:0]          Write_Count
);

   reg_onehot_t en;
   reg_onehot_t onehot_q;
   logic [15:0] count_q;
   logic [15:0] count_d;

   write_decoder u_write_decoder (
      .we_i   (RegWrite),
      .addr_i (Write_Register),
      .en_o   (en)
   );

   // One enabled flop per register; register 0 is a constant.
   for (genvar k = 0; k < REG_COUNT; k++) begin : g_reg
      if (k == ZERO_REG) begin : g_zero
         assign Reg_Q[k*N +: N] = '0;
      end else begin : g_flop
         logic [N-1:0] data_q;

         // NOTE: every storage register is in the reset branch; the bank is
         // built from flops, so this costs nothing and avoids X after reset.
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               data_q <= RESET_VALUE;
            end else if (en[k]) begin
               // NOTE: sequential state always uses non-blocking assignment so
               // all flops sample pre-edge values regardless of block order.
               data_q <= Write_Data;
            end
         end

         assign Reg_Q[k*N +: N] = data_q;
      end
   end

   // The decoder already forces bit 0 low, so any set bit is a committed write.
   always_comb begin
      count_d = count_q;
      if ((|en) && (count_q != COUNT_MAX)) count_d = count_q + 16'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         onehot_q <= '0;
         count_q  <= '0;
      end else begin
         onehot_q <= en;
         count_q  <= count_d;
      end
   end

   assign Write_Onehot = onehot_q;
   assign Write_Count  = count_q;

endmodule : register_write_bank

// File: tb/tb_register_write_bank.sv
// -----------------------------------------------------------------------------
// tb_register_write_bank
// Scoreboard bench: the stimulus process updates a reference model and queues
// the state expected after the next clock edge; a monitor on the falling edge
// pops and compares each entry in the cycle it becomes due.
// -----------------------------------------------------------------------------
module tb_register_write_bank;

   localparam int          N       = 32;
   localparam logic [31:0] RST_VAL = 32'h0;

   typedef struct {
      int              due;
      logic [32*N-1:0] regs;
      logic [31:0]     onehot;
      logic [15:0]     cnt;
   } exp_t;

   logic            clk = 1'b0;
   logic            reset;
   logic            RegWrite;
   logic [4:0]      Write_Register;
   logic [N-1:0]    Write_Data;
   logic [32*N-1:0] Reg_Q;
   logic [31:0]     Write_Onehot;
   logic [15:0]     Write_Count;

   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc      = 0;
   exp_t sb[$];

   logic [31:0] m_regs [32];
   logic [31:0] m_onehot;
   logic [15:0] m_cnt;

   register_write_bank #(.N(N), .RESET_VALUE(RST_VAL)) dut (
      .clk            (clk),
      .reset          (reset),
      .RegWrite       (RegWrite),
      .Write_Register (Write_Register),
      .Write_Data     (Write_Data),
      .Reg_Q          (Reg_Q),
      .Write_Onehot   (Write_Onehot),
      .Write_Count    (Write_Count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic compare(input string tag, input exp_t e);
      for (int k = 0; k < 32; k++)
         check($sformatf("%s reg%0d", tag, k), Reg_Q[k*N +: N], e.regs[k*N +: N]);
      check({tag, " onehot"}, Write_Onehot, e.onehot);
      check({tag, " count"}, {16'h0, Write_Count}, {16'h0, e.cnt});
   endtask

   function automatic exp_t model_snapshot(input int due);
      exp_t e;
      e.due = due;
      for (int k = 0; k < 32; k++) e.regs[k*N +: N] = m_regs[k];
      e.onehot = m_onehot;
      e.cnt    = m_cnt;
      return e;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 32; k++) m_regs[k] = (k == 0) ? 32'h0 : RST_VAL;
      m_onehot = '0;
      m_cnt    = '0;
   endtask

   // One cycle of stimulus, driven just after a rising edge.
   task automatic do_cycle(input logic rst_v, input logic we, input logic [4:0] addr,
                           input logic [31:0] data, input bit chk);
      @(posedge clk);
      #1;
      reset          = rst_v;
      RegWrite       = we;
      Write_Register = addr;
      Write_Data     = data;
      if (!rst_v) begin
         model_reset();
      end else if (we && addr != 5'd0) begin
         m_regs[addr] = data;
         if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
         m_onehot = 32'd1 << addr;
      end else begin
         m_onehot = '0;
      end
      if (chk) sb.push_back(model_snapshot(cyc + 1));
   endtask

   task automatic drain();
      int budget = 10;
      while (sb.size() != 0 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      n_checks++;
      if (sb.size() != 0) begin
         n_errors++;
         $display("FAIL drain_timeout: %0d entries pending, required 0", sb.size());
         sb.delete();
      end
   endtask

   // Monitor: compare every entry whose due cycle has arrived.
   always @(negedge clk) begin
      while (sb.size() != 0 && sb[0].due <= cyc) begin
         exp_t e;
         e = sb.pop_front();
         if (e.due < cyc) begin
            n_checks++;
            n_errors++;
            $display("FAIL late_entry: checked at cycle %0d, due %0d", cyc, e.due);
         end else begin
            compare("sb", e);
         end
      end
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      // Reset from time zero with an active write request, before any edge.
      reset          = 1'b0;
      RegWrite       = 1'b1;
      Write_Register = 5'd4;
      Write_Data     = $urandom;
      #2;
      compare("async_reset_t0", model_snapshot(0));

      // Reset held for 3 cycles with random write traffic.
      for (int i = 0; i < 3; i++)
         do_cycle(1'b0, 1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b1);

      // Release with no write pending.
      do_cycle(1'b1, 1'b0, 5'd0, 32'h0, 1'b1);

      // Write and read back every register 1..31.
      for (int i = 1; i < 32; i++)
         do_cycle(1'b1, 1'b1, 5'(i), 32'hA5A50000 + 32'(i), 1'b1);

      // Write to register 0 is discarded and not counted.
      do_cycle(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1);

      // Enable gating.
      for (int i = 0; i < 4; i++)
         do_cycle(1'b1, 1'b0, 5'd5, 32'h12345678, 1'b1);

      // Back-to-back writes, then register 7 overwritten and register 8 written.
      do_cycle(1'b1, 1'b1, 5'd7, 32'd1, 1'b1);
      do_cycle(1'b1, 1'b1, 5'd7, 32'd2, 1'b1);
      do_cycle(1'b1, 1'b1, 5'd7, 32'd3, 1'b1);
      do_cycle(1'b1, 1'b1, 5'd7, 32'h0000_0077, 1'b1);
      do_cycle(1'b1, 1'b1, 5'd8, 32'h0000_0088, 1'b1);
      do_cycle(1'b1, 1'b0, 5'd0, 32'h0, 1'b1);
      drain();

      // Mid-simulation reset takes effect without a clock edge.
      @(posedge clk);
      #1;
      reset          = 1'b0;
      RegWrite       = 1'b1;
      Write_Register = 5'd9;
      Write_Data     = $urandom;
      model_reset();
      #1;
      compare("async_reset_mid", model_snapshot(0));
      do_cycle(1'b0, 1'b1, 5'd9, $urandom, 1'b1);
      do_cycle(1'b0, 1'b1, 5'd10, $urandom, 1'b1);
      do_cycle(1'b1, 1'b0, 5'd0, 32'h0, 1'b1);

      // Counter saturation: only the last few writes are scored.
      for (int i = 0; i < 65540; i++)
         do_cycle(1'b1, 1'b1, 5'd3, 32'(i), (i >= 65532));
      do_cycle(1'b1, 1'b0, 5'd0, 32'h0, 1'b1);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_register_write_bank

// File: doc/register_write_bank.md
Name: register_write_bank

Overview:
- Write side of the 32-entry register file: decodes a 5-bit write address into one-hot enables and stores data in 32 N-bit registers.
- Drives the 32 stored words as one flat bus, which is sliced to feed d0..d31 of the read-port multiplexers, with two read ports per file.
- Register 0 is hardwired to zero.

Parameters:
- N, 32, data width of every register and of Write_Data.
- RESET_VALUE, 0, value loaded into registers 1..31 on reset. Truncated or zero-extended to N bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset. Clears every register while low.
- RegWrite  input  1  write enable from the control unit.
- Write_Register  input  5  destination register index 0..31.
- Write_Data  input  N  value to store.
- Reg_Q  output  32*N  all register contents. Register k occupies bits [k*N+N-1 : k*N].
- Write_Onehot  output  32  registered copy of the one-hot enable that was applied on the last edge. Debug and verification use only.
- Write_Count  output  16  number of committed writes since reset. Saturates at 16'hFFFF.

Behaviour:
- Reset (reset=0, asynchronous, no clock needed):
  - Registers 1..31 take RESET_VALUE.
  - Register 0 is 0.
  - Write_Onehot = 0 and Write_Count = 0.
  - Outputs hold these values for as long as reset stays low, and all writes are ignored.
- Reset release: first active edge is the first rising clk edge with reset=1. No synchronizer inside the block; the top level handles reset synchronization.
- Decoder is combinational: en[i] = RegWrite && (Write_Register == i) for i = 1..31. en[0] is always 0.
- Write timing: on a rising clk edge with en[i]=1, register i takes Write_Data. Reg_Q reflects the new value after that edge, so latency is 1 clock from presentation to visibility.
- No read-during-write bypass in this block. A read of register i in the same cycle as a write to i returns the old value. Forwarding belongs to the hazard unit.
- Write to index 0 (RegWrite=1, Write_Register=0):
  - Register 0 stays 0.
  - Write_Onehot becomes 0 on that edge.
  - Write_Count does not increment, because it counts committed writes only.
- RegWrite=0: no register changes, Write_Onehot becomes 0, and Write_Count holds.
- Write_Onehot: on every rising edge it loads en[31:0]. At most one bit is ever set.
- Write_Count:
  - Increments by 1 on every edge where any en[i]=1 with i != 0.
  - Holds at 16'hFFFF once reached; it does not wrap.
- X-safety: if Write_Register is unknown while RegWrite=0, no register changes. Implement the decoder as a full case over all 32 indices so synthesis infers no latches.
- Reset asserted mid-cycle: takes effect immediately and asynchronously. A write on the same edge that reset releases is not required to commit; the bench must not depend on it.
- Width rules: Write_Data is stored unmodified with no sign extension. Reg_Q packing is fixed little-endian by index.

Decomposition:
- Shared package or include (regfile_defs): REG_COUNT=32, REG_ADDR_W=5, ZERO_REG=0. The read mux and this block both use it.
- One natural sub-module: write_decoder (5-bit to 32 one-hot with enable, bit 0 forced low).
- The 32 registers are a generate loop of one N-bit enabled flop each, with index 0 tied to zero.

Test Plan:
- Reset check: assert reset=0 with random Write_Data and RegWrite=1 for 3 cycles -> Reg_Q all zero, Write_Count=0, Write_Onehot=0 throughout, with no clock dependence. Also check mid-simulation reset after writes.
- Write and readback:
  - For each i = 1..31, write 32'hA5A50000+i -> after 1 clock, slice i equals that value and all other slices are unchanged.
  - Write_Onehot = 1<<i on each write.
  - Write_Count = 31 at the end.
- Register zero: RegWrite=1, Write_Register=0, Write_Data=32'hFFFFFFFF -> slice 0 stays 0, Write_Onehot=0, Write_Count unchanged.
- Enable gating: RegWrite=0, Write_Register=5, Write_Data=32'h12345678 for 4 cycles -> register 5 keeps its prior value and Write_Count holds.
- Back-to-back writes: writes to register 7 on consecutive cycles with values 1, 2, 3 -> slice 7 reads 1, 2, 3 on successive cycles. Then an overwrite of register 7 while register 8 is written next cycle -> both retain their last writes.
- Counter saturation: force Write_Count near limit (or run 65540 writes to register 3) -> Write_Count stops at 16'hFFFF and register 3 still updates.
